// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that lets NUM_REQ requesters share one
// FIFO write port. Grant, write enable and write data are combinational, so a
// word is written in the same cycle it is granted.
// Optional burst ownership is enabled by defining FIFO_ARB_BURST_EN. In that
// mode a requester keeps the port for up to BURST_LEN beats.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BURST_LEN  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic                          full,
    output logic [NUM_REQ-1:0]            gnt,
    output logic                          Wr_enable,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic                          owner_busy,
    output logic [15:0]                   wr_count
);

    localparam int unsigned PTR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned BEAT_W = $clog2(BURST_LEN + 1);

`ifdef FIFO_ARB_BURST_EN
    localparam bit BURST_EN = (BURST_LEN > 1);
`else
    localparam bit BURST_EN = 1'b0;
`endif

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                  state_q;
    logic [PTR_W-1:0]        ptr_q;
    logic [PTR_W-1:0]        owner_q;
    logic [BEAT_W-1:0]       beat_q;
    logic                    busy_q;
    logic [15:0]             cnt_q;

    logic [NUM_REQ-1:0]      gnt_c;
    logic [PTR_W-1:0]        win_c;
    logic                    found_c;
    int unsigned             idx_c;
    logic [DATA_WIDTH-1:0]   data_c;
    logic                    fire_c;

    // Pointer advance with wrap from NUM_REQ-1 back to 0.
    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NUM_REQ - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // Grant selection: burst owner only while holding, else round-robin from ptr.
    always_comb begin
        gnt_c   = '0;
        win_c   = '0;
        found_c = 1'b0;
        idx_c   = 0;
        if (!reset && !full) begin
            if (state_q == HOLD) begin
                if (req[owner_q]) begin
                    gnt_c[owner_q] = 1'b1;
                    win_c          = owner_q;
                end
            end else begin
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    idx_c = 32'(ptr_q) + k;
                    if (idx_c >= NUM_REQ) begin
                        idx_c = idx_c - NUM_REQ;
                    end
                    if (!found_c && req[PTR_W'(idx_c)]) begin
                        found_c              = 1'b1;
                        gnt_c[PTR_W'(idx_c)] = 1'b1;
                        win_c                = PTR_W'(idx_c);
                    end
                end
            end
        end
    end

    // AND-OR write data mux; zero when nothing is granted.
    always_comb begin
        data_c = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_c[i]) begin
                data_c = data_c | req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign fire_c     = |gnt_c;
    assign gnt        = gnt_c;
    assign Wr_enable  = fire_c;
    assign data_in    = data_c;
    assign owner_busy = busy_q;
    assign wr_count   = cnt_q;

    // Ownership FSM, rotation pointer and saturating write counter; all hold while full.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            beat_q  <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else if (!full) begin
            if (fire_c && (cnt_q != 16'hFFFF)) begin
                cnt_q <= cnt_q + 16'd1;
            end
            case (state_q)
                IDLE: begin
                    if (fire_c) begin
                        if (BURST_EN) begin
                            state_q <= HOLD;
                            owner_q <= win_c;
                            beat_q  <= BEAT_W'(1);
                            busy_q  <= 1'b1;
                        end else begin
                            ptr_q <= inc_ptr(win_c);
                        end
                    end
                end
                HOLD: begin
                    if (fire_c) begin
                        if ((beat_q + BEAT_W'(1)) == BEAT_W'(BURST_LEN)) begin
                            state_q <= IDLE;
                            ptr_q   <= inc_ptr(owner_q);
                            beat_q  <= '0;
                            busy_q  <= 1'b0;
                        end else begin
                            beat_q <= beat_q + BEAT_W'(1);
                        end
                    end else begin
                        // Owner dropped its request: give up the port after one bubble.
                        state_q <= IDLE;
                        ptr_q   <= inc_ptr(owner_q);
                        beat_q  <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=32, BURST_LEN=4).
// Burst scenarios run when FIFO_ARB_BURST_EN is defined, rotation scenarios otherwise.
module tb_fifo_wr_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned BL = 4;

`ifdef FIFO_ARB_BURST_EN
    localparam bit BURST = 1'b1;
`else
    localparam bit BURST = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req;
    logic [NR*DW-1:0]  req_data;
    logic              full;
    logic [NR-1:0]     gnt;
    logic              Wr_enable;
    logic [DW-1:0]     data_in;
    logic              owner_busy;
    logic [15:0]       wr_count;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .NUM_REQ   (NR),
        .DATA_WIDTH(DW),
        .BURST_LEN (BL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .full      (full),
        .gnt       (gnt),
        .Wr_enable (Wr_enable),
        .data_in   (data_in),
        .owner_busy(owner_busy),
        .wr_count  (wr_count)
    );

    typedef struct packed {
        logic [3:0]  g;
        logic        we;
        logic [31:0] data;
        logic        busy;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model state
    logic [1:0]  m_ptr   = 2'd0;
    logic [1:0]  m_owner = 2'd0;
    int          m_beat  = 0;
    bit          m_hold  = 1'b0;
    int          m_cnt   = 0;
    logic [31:0] words[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // One clock cycle: drive, predict, compare before the edge, then advance the model.
    task automatic step(input logic [3:0] r, input bit f, input bit rst, input bit check, input string tag);
        exp_t       e;
        logic [3:0] g;
        logic [1:0] w;
        logic [1:0] idx;
        @(negedge clk);
        req   = r;
        full  = f;
        reset = rst;
        for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = words[i];
        g = 4'd0;
        w = 2'd0;
        if (!rst && !f) begin
            if (m_hold) begin
                if (r[m_owner]) begin
                    g[m_owner] = 1'b1;
                    w = m_owner;
                end
            end else begin
                for (int k = 0; k < 4; k++) begin
                    idx = m_ptr + 2'(k);
                    if (g == 4'd0 && r[idx]) begin
                        g[idx] = 1'b1;
                        w = idx;
                    end
                end
            end
        end
        e.g    = g;
        e.we   = (g != 4'd0);
        e.data = (g != 4'd0) ? words[w] : 32'd0;
        e.busy = m_hold;
        e.cnt  = 16'(m_cnt);
        if (check) exp_q.push_back(e);
        #2;
        if (check) begin
            e = exp_q.pop_front();
            chk({tag, "/gnt"},  32'(gnt),        32'(e.g));
            chk({tag, "/we"},   32'(Wr_enable),  32'(e.we));
            chk({tag, "/data"}, data_in,         e.data);
            chk({tag, "/busy"}, 32'(owner_busy), 32'(e.busy));
            chk({tag, "/cnt"},  32'(wr_count),   32'(e.cnt));
        end
        if (rst) begin
            m_ptr = 2'd0; m_owner = 2'd0; m_beat = 0; m_hold = 1'b0; m_cnt = 0;
        end else if (!f) begin
            if (g != 4'd0 && m_cnt < 65535) m_cnt++;
            if (m_hold) begin
                if (g != 4'd0) begin
                    m_beat++;
                    if (m_beat == BL) begin
                        m_hold = 1'b0; m_beat = 0; m_ptr = m_owner + 2'd1;
                    end
                end else begin
                    m_hold = 1'b0; m_beat = 0; m_ptr = m_owner + 2'd1;
                end
            end else if (g != 4'd0) begin
                if (BURST && BL > 1) begin
                    m_hold = 1'b1; m_owner = w; m_beat = 1;
                end else begin
                    m_ptr = w + 2'd1;
                end
            end
        end
    endtask

    task automatic set_words_a0();
        for (int i = 0; i < 4; i++) words[i] = 32'hA0 + 32'(i);
    endtask

    logic [3:0] tbl_g[5];

    initial begin
        reset = 1'b1;
        req   = '0;
        full  = 1'b0;
        req_data = '0;
        set_words_a0();
        tbl_g[0] = 4'b0001; tbl_g[1] = 4'b0010; tbl_g[2] = 4'b0100;
        tbl_g[3] = 4'b1000; tbl_g[4] = 4'b0001;

        // Reset held with all requesters asking: no grant, counter cleared.
        step(4'hF, 1'b0, 1'b1, 1'b0, "rst0");
        step(4'hF, 1'b0, 1'b1, 1'b1, "rst1");
        step(4'hF, 1'b0, 1'b1, 1'b1, "rst2");
        chk("rst_cnt_zero", 32'(wr_count), 32'd0);

        if (!BURST) begin
            // Plain rotation across all four requesters.
            for (int i = 0; i < 5; i++) begin
                step(4'hF, 1'b0, 1'b0, 1'b1, "rr");
                chk("rr_tbl_gnt", 32'(gnt), 32'(tbl_g[i]));
                chk("rr_tbl_data", data_in, 32'hA0 + 32'(i % 4));
            end
            // Full stalls everything; rotation resumes from where it stopped.
            step(4'b1010, 1'b1, 1'b0, 1'b1, "full0");
            step(4'b1010, 1'b1, 1'b0, 1'b1, "full1");
            step(4'b1010, 1'b1, 1'b0, 1'b1, "full2");
            chk("full_cnt_hold", 32'(wr_count), 32'd5);
            step(4'b1010, 1'b0, 1'b0, 1'b1, "unfull0");
            chk("unfull0_tbl", 32'(gnt), 32'b0010);
            step(4'b1010, 1'b0, 1'b0, 1'b1, "unfull1");
            chk("unfull1_tbl", 32'(gnt), 32'b1000);
        end else begin
            // Two full bursts back to back.
            for (int i = 0; i < 8; i++) begin
                step(4'b0101, 1'b0, 1'b0, 1'b1, "burst");
                chk("burst_tbl_gnt", 32'(gnt), (i < 4) ? 32'b0001 : 32'b0100);
            end
            step(4'b0101, 1'b0, 1'b1, 1'b1, "brst_rst");
            // Owner drops early, bubble, then requester 2; reset mid-burst.
            step(4'b0101, 1'b0, 1'b0, 1'b1, "drop_b0");
            step(4'b0101, 1'b0, 1'b0, 1'b1, "drop_b1");
            step(4'b0100, 1'b0, 1'b0, 1'b1, "bubble");
            chk("bubble_tbl", 32'(gnt), 32'd0);
            step(4'b0100, 1'b0, 1'b0, 1'b1, "r2_b0");
            chk("r2_tbl", 32'(gnt), 32'b0100);
            step(4'b0100, 1'b0, 1'b0, 1'b1, "r2_b1");
            step(4'b0101, 1'b0, 1'b1, 1'b1, "mid_rst");
            step(4'b0101, 1'b0, 1'b0, 1'b1, "post_rst");
            chk("post_rst_tbl", 32'(gnt), 32'b0001);
            // Full while holding keeps the burst intact.
            step(4'b0101, 1'b1, 1'b0, 1'b1, "hold_full0");
            step(4'b0101, 1'b1, 1'b0, 1'b1, "hold_full1");
            for (int i = 0; i < 4; i++) step(4'b0101, 1'b0, 1'b0, 1'b1, "hold_resume");
        end

        // Random requests, data, full and occasional reset.
        for (int n = 0; n < 40; n++) begin
            for (int i = 0; i < 4; i++) words[i] = $urandom;
            step(4'($urandom_range(0, 15)), ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 19) == 0), 1'b1, "rand");
        end

        // Counter saturation over 65540 transfers.
        set_words_a0();
        step(4'hF, 1'b0, 1'b1, 1'b1, "sat_rst");
        for (int n = 0; n < 65533; n++) step(4'hF, 1'b0, 1'b0, 1'b0, "");
        for (int n = 0; n < 7; n++) step(4'hF, 1'b0, 1'b0, 1'b1, "sat");
        step(4'h0, 1'b0, 1'b0, 1'b1, "sat_end");
        chk("sat_tbl", 32'(wr_count), 32'hFFFF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
